// File: rtl/aes_round_ctrl.sv
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Sequencing FSM for the iterative AES cipher datapath.
//            Optional macro AES_DECRYPT_EN adds i_decrypt with a descending
//            round-key order.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
    parameter int CNT_SIZE = 4,
    parameter int NR_128   = 10,
    parameter int NR_192   = 12,
    parameter int NR_256   = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [1:0]          i_key_size,
`ifdef AES_DECRYPT_EN
    input  logic                i_decrypt,
`endif
    input  logic                i_rk_valid,
    output logic [CNT_SIZE-1:0] o_rk_idx,
    output logic                o_dp_load,
    output logic                o_dp_round,
    output logic                o_dp_final,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic                o_busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [CNT_SIZE-1:0] ONE = CNT_SIZE'(1);

    logic [2:0]          state, state_next;
    logic [CNT_SIZE-1:0] rk_idx, rk_idx_next;
    logic [CNT_SIZE-1:0] nr, nr_next, nr_sel;
    logic                dec, dec_next, dec_in;
    logic                accept;

`ifdef AES_DECRYPT_EN
    assign dec_in = i_decrypt;
`else
    assign dec_in = 1'b0;
`endif

    assign accept   = i_in_valid && (state == S_IDLE);
    assign o_rk_idx = rk_idx;

    // Reserved key size 2'b11 falls back to the AES-128 round count.
    always_comb begin
        case (i_key_size)
            2'b01:   nr_sel = CNT_SIZE'(NR_192);
            2'b10:   nr_sel = CNT_SIZE'(NR_256);
            default: nr_sel = CNT_SIZE'(NR_128);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rk_idx <= '0;
            nr     <= CNT_SIZE'(NR_128);
            dec    <= 1'b0;
        end else begin
            state  <= state_next;
            rk_idx <= rk_idx_next;
            nr     <= nr_next;
            dec    <= dec_next;
        end
    end

    always_comb begin
        state_next  = state;
        rk_idx_next = rk_idx;
        nr_next     = nr;
        dec_next    = dec;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nr_next     = nr_sel;
                    dec_next    = dec_in;
                    rk_idx_next = dec_in ? nr_sel : '0;
                    state_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_rk_valid) begin
                    rk_idx_next = dec ? (nr - ONE) : ONE;
                    state_next  = S_ROUND;
                end
            end
            S_ROUND: begin
                if (i_rk_valid) begin
                    rk_idx_next = dec ? (rk_idx - ONE) : (rk_idx + ONE);
                    // Last middle round is the one just before the final key.
                    if (rk_idx == (dec ? ONE : (nr - ONE)))
                        state_next = S_FINAL;
                end
            end
            S_FINAL: begin
                if (i_rk_valid)
                    state_next = S_HOLD;
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    rk_idx_next = '0;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                rk_idx_next = '0;
                state_next  = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_in_ready  = (state == S_IDLE);
        o_busy      = (state != S_IDLE);
        o_dp_load   = (state == S_LOAD) && i_rk_valid;
        o_dp_round  = ((state == S_ROUND) || (state == S_FINAL)) && i_rk_valid;
        o_dp_final  = (state == S_FINAL) && i_rk_valid;
        o_out_valid = (state == S_HOLD);
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// Module   : tb_aes_round_ctrl
// Purpose  : Randomized and directed bench for aes_round_ctrl against a
//            transaction-level model (step count per accepted block).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] key_size = 2'b00;
    logic       decrypt = 1'b0;
    logic       rk_valid = 1'b0;
    logic [3:0] rk_idx;
    logic       dp_load, dp_round, dp_final;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;

    int checks = 0;
    int passed = 0;
    int errors = 0;

    // Model: a block is a walk of nr+1 key-consuming steps, then a hold.
    bit m_busy = 0;
    bit m_hold = 0;
    bit m_dec  = 0;
    int m_step = 0;
    int m_nr   = 10;
    bit seen_ov;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_key_size  (key_size),
`ifdef AES_DECRYPT_EN
        .i_decrypt   (decrypt),
`endif
        .i_rk_valid  (rk_valid),
        .o_rk_idx    (rk_idx),
        .o_dp_load   (dp_load),
        .o_dp_round  (dp_round),
        .o_dp_final  (dp_final),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nr_of(input logic [1:0] ks);
        return (ks == 2'b01) ? 12 : (ks == 2'b10) ? 14 : 10;
    endfunction

    task automatic run_cycle(input logic iv, input logic [1:0] ks, input logic rkv,
                             input logic ordy, input logic rn, input logic dc);
        bit active;
        int e_idx;
        @(posedge clk);
        #1;
        in_valid  = iv;
        key_size  = ks;
        rk_valid  = rkv;
        out_ready = ordy;
        rst_n     = rn;
        decrypt   = dc;
        if (!rn) begin
            m_busy = 0;
            m_hold = 0;
        end
        @(negedge clk);
        active = m_busy && !m_hold;
        e_idx  = !m_busy ? 0 : m_hold ? (m_dec ? 0 : m_nr)
               : (m_dec ? m_nr - m_step : m_step);
        check("rk_idx", int'(rk_idx), e_idx);
        check("ctl{rdy,busy,ov,load,round,final}",
              int'({in_ready, busy, out_valid, dp_load, dp_round, dp_final}),
              int'({!m_busy, m_busy, m_busy && m_hold,
                    active && rkv && (m_step == 0),
                    active && rkv && (m_step >= 1),
                    active && rkv && (m_step == m_nr)}));
        seen_ov = out_valid;
        if (rn) begin
            if (!m_busy) begin
                if (iv) begin
                    m_busy = 1;
                    m_hold = 0;
                    m_step = 0;
                    m_nr   = nr_of(ks);
`ifdef AES_DECRYPT_EN
                    m_dec  = dc;
`else
                    m_dec  = 0;
`endif
                end
            end else if (!m_hold) begin
                if (rkv) begin
                    if (m_step == m_nr) m_hold = 1;
                    else m_step++;
                end
            end else if (ordy) begin
                m_busy = 0;
                m_hold = 0;
            end
        end
    endtask

    // Accepts one block, optionally stalls the key schedule, measures
    // accept-to-out_valid latency while scrambling i_key_size mid-flight.
    task automatic directed(input logic [1:0] ks, input int st_at, input int st_len,
                            input logic dc);
        int lat;
        lat = -1;
        run_cycle(1'b1, ks, 1'b1, 1'b1, 1'b1, dc);
        for (int c = 1; c < 40 && lat < 0; c++) begin
            run_cycle(1'b0, ~ks, !(c >= st_at && c < st_at + st_len), 1'b1, 1'b1, dc);
            if (seen_ov) lat = c;
        end
        check("latency", lat, nr_of(ks) + 2 + st_len);
    endtask

    initial begin
        run_cycle(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 4; k++) directed(2'(k), 0, 0, 1'b0);
        directed(2'b00, 6, 3, 1'b0);
`ifdef AES_DECRYPT_EN
        directed(2'b00, 0, 0, 1'b1);
        directed(2'b10, 4, 2, 1'b1);
`endif

        // Backpressure: out_valid held, new requests ignored until handshake.
        run_cycle(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 18; c++) run_cycle(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_cycle(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset pulse mid-block, then a fresh block restarts at index 0.
        run_cycle(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) run_cycle(1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        check("idx_before_reset", int'(rk_idx), 7);
        run_cycle(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        directed(2'b10, 0, 0, 1'b0);

        for (int c = 0; c < 2500; c++) begin
            logic dc;
`ifdef AES_DECRYPT_EN
            dc = 1'($urandom);
`else
            dc = 1'b0;
`endif
            run_cycle(($urandom % 3) == 0, 2'($urandom), ($urandom % 4) != 0,
                      ($urandom % 3) != 0, ($urandom % 300) != 0, dc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
